// File: rtl/sat_pkg.sv
// Shared SAT types: scheduler state encoding and
// literal/conflict helpers used by the clause evaluator.
`include "sysdef.svh"

package sat_pkg;

    localparam int LANES = `VAR_PER_CLAUSE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EVAL,
        EMIT,
        FINISH
    } bcp_state_e;

    typedef logic [LANES-1:0] lane_vec_t;

    function automatic lane_vec_t lit_true(
        input lane_vec_t mask,
        input lane_vec_t unassign,
        input lane_vec_t val,
        input lane_vec_t pole
    );
        return mask & ~unassign & (val ^ pole);
    endfunction

    // Falsified: some lane in use, none open, none satisfied.
    function automatic logic is_conflict(
        input lane_vec_t mask,
        input lane_vec_t unassign,
        input lane_vec_t val,
        input lane_vec_t pole
    );
        return (|mask)
            && !(|(mask & unassign))
            && !(|lit_true(mask, unassign, val, pole));
    endfunction

endpackage

// File: rtl/sub_clause_evaluator.sv
// Combinational clause check: conflict, unit detection and
// the implied assignment for the single open lane.
`include "sysdef.svh"

module sub_clause_evaluator
    import sat_pkg::*;
#(
    parameter int VAR_PER_CLAUSE = `VAR_PER_CLAUSE,
    parameter int MAX_VARS_BITS  = `MAX_VARS_BITS
) (
    input  logic [VAR_PER_CLAUSE-1:0]                    unassign,
    input  logic [VAR_PER_CLAUSE-1:0]                    clause_mask,
    input  logic [VAR_PER_CLAUSE-1:0]                    clause_pole,
    input  logic [VAR_PER_CLAUSE-1:0]                    val,
    input  logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] variable,
    output logic                                         conflict,
    output logic                                         unit_clause,
    output logic [MAX_VARS_BITS-1:0]                     implied_variable,
    output logic                                         new_val
);

    logic [VAR_PER_CLAUSE-1:0] lits;
    logic [VAR_PER_CLAUSE-1:0] open_lanes;

    always_comb begin
        lits        = lit_true(clause_mask, unassign, val, clause_pole);
        open_lanes  = clause_mask & unassign;
        conflict    = is_conflict(clause_mask, unassign, val, clause_pole);
        unit_clause = !(|lits)
                   && (open_lanes != '0)
                   && ((open_lanes & (open_lanes - VAR_PER_CLAUSE'(1))) == '0);
        implied_variable = '0;
        new_val          = 1'b0;
        // The implied value is whatever makes the open literal true.
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            if (open_lanes[i]) begin
                implied_variable = variable[i];
                new_val          = ~clause_pole[i];
            end
        end
    end

endmodule

// File: rtl/sysdef.svh
// System-wide sizing for the SAT engine.
// Lane count per clause and variable-index width.
`ifndef SYSDEF_SVH
`define SYSDEF_SVH
`define VAR_PER_CLAUSE 5
`define MAX_VARS_BITS 8
`endif

// File: rtl/bcp_scheduler.sv
// Boolean constraint propagation pass scheduler: walks the clause
// list, stops on a conflict and streams out unit implications.
`include "sysdef.svh"

module bcp_scheduler
    import sat_pkg::*;
#(
    parameter int CLAUSE_BITS    = 8,
    parameter int VAR_PER_CLAUSE = `VAR_PER_CLAUSE,
    parameter int MAX_VARS_BITS  = `MAX_VARS_BITS
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic                                         start,
    input  logic [CLAUSE_BITS-1:0]                       num_clauses,
    input  logic                                         abort,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         conflict,
    output logic [CLAUSE_BITS-1:0]                       conflict_clause,
    output logic                                         clause_rd_en,
    output logic [CLAUSE_BITS-1:0]                       clause_addr,
    input  logic [VAR_PER_CLAUSE-1:0]                    unassign,
    input  logic [VAR_PER_CLAUSE-1:0]                    clause_mask,
    input  logic [VAR_PER_CLAUSE-1:0]                    clause_pole,
    input  logic [VAR_PER_CLAUSE-1:0]                    val,
    input  logic [VAR_PER_CLAUSE-1:0][MAX_VARS_BITS-1:0] variable,
    output logic                                         imp_valid,
    input  logic                                         imp_ready,
    output logic [MAX_VARS_BITS-1:0]                     imp_var,
    output logic                                         imp_val
);

    bcp_state_e               state_q, state_d;
    logic [CLAUSE_BITS-1:0]   index_q, index_d;
    logic [CLAUSE_BITS-1:0]   num_q, num_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     conflict_q, conflict_d;
    logic [CLAUSE_BITS-1:0]   cclause_q, cclause_d;
    logic                     imp_valid_q, imp_valid_d;
    logic [MAX_VARS_BITS-1:0] imp_var_q, imp_var_d;
    logic                     imp_val_q, imp_val_d;

    logic                     ev_conflict;
    logic                     ev_unit;
    logic [MAX_VARS_BITS-1:0] ev_var;
    logic                     ev_val;
    logic                     advance;

    sub_clause_evaluator #(
        .VAR_PER_CLAUSE (VAR_PER_CLAUSE),
        .MAX_VARS_BITS  (MAX_VARS_BITS)
    ) u_eval (
        .unassign         (unassign),
        .clause_mask      (clause_mask),
        .clause_pole      (clause_pole),
        .val              (val),
        .variable         (variable),
        .conflict         (ev_conflict),
        .unit_clause      (ev_unit),
        .implied_variable (ev_var),
        .new_val          (ev_val)
    );

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        num_d      = num_q;
        conflict_d = conflict_q;
        cclause_d  = cclause_q;
        imp_var_d  = imp_var_q;
        imp_val_d  = imp_val_q;
        advance    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    conflict_d = 1'b0;
                    cclause_d  = '0;
                    num_d      = num_clauses;
                    index_d    = '0;
                    state_d    = (num_clauses == '0) ? FINISH : FETCH;
                end
            end
            FETCH: state_d = EVAL;
            EVAL: begin
                if (ev_conflict) begin
                    conflict_d = 1'b1;
                    cclause_d  = index_q;
                    state_d    = FINISH;
                end else if (ev_unit) begin
                    imp_var_d = ev_var;
                    imp_val_d = ev_val;
                    state_d   = EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            EMIT:    advance = imp_ready;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Last index is num-1, so the index never needs to wrap.
        if (advance) begin
            if (index_q == num_q - CLAUSE_BITS'(1)) begin
                state_d = FINISH;
            end else begin
                index_d = index_q + CLAUSE_BITS'(1);
                state_d = FETCH;
            end
        end

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            conflict_d = 1'b0;
            cclause_d  = '0;
        end

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
        imp_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            index_q     <= '0;
            num_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            conflict_q  <= 1'b0;
            cclause_q   <= '0;
            imp_valid_q <= 1'b0;
            imp_var_q   <= '0;
            imp_val_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            num_q       <= num_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            conflict_q  <= conflict_d;
            cclause_q   <= cclause_d;
            imp_valid_q <= imp_valid_d;
            imp_var_q   <= imp_var_d;
            imp_val_q   <= imp_val_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign conflict        = conflict_q;
    assign conflict_clause = cclause_q;
    assign imp_valid       = imp_valid_q;
    assign imp_var         = imp_var_q;
    assign imp_val         = imp_val_q;
    assign clause_rd_en    = (state_q == FETCH);
    assign clause_addr     = index_q;

endmodule

// File: tb/tb_bcp_scheduler.sv
// Directed bench for bcp_scheduler: clause memory model with one
// cycle read latency and a stallable implication consumer.
module tb_bcp_scheduler;

    logic           clock;
    logic           reset_n;
    logic           start;
    logic [7:0]     num_clauses;
    logic           abort;
    logic           busy;
    logic           done;
    logic           conflict;
    logic [7:0]     conflict_clause;
    logic           clause_rd_en;
    logic [7:0]     clause_addr;
    logic [4:0]     unassign;
    logic [4:0]     clause_mask;
    logic [4:0]     clause_pole;
    logic [4:0]     val;
    logic [4:0][7:0] variable;
    logic           imp_valid;
    logic           imp_ready;
    logic [7:0]     imp_var;
    logic           imp_val;

    bcp_scheduler #(
        .CLAUSE_BITS    (8),
        .VAR_PER_CLAUSE (5),
        .MAX_VARS_BITS  (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .num_clauses     (num_clauses),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .conflict        (conflict),
        .conflict_clause (conflict_clause),
        .clause_rd_en    (clause_rd_en),
        .clause_addr     (clause_addr),
        .unassign        (unassign),
        .clause_mask     (clause_mask),
        .clause_pole     (clause_pole),
        .val             (val),
        .variable        (variable),
        .imp_valid       (imp_valid),
        .imp_ready       (imp_ready),
        .imp_var         (imp_var),
        .imp_val         (imp_val)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [4:0]      mask_m [8];
    logic [4:0]      pole_m [8];
    logic [4:0]      un_m   [8];
    logic [4:0]      val_m  [8];
    logic [4:0][7:0] var_m  [8];

    always @(posedge clock) begin
        if (clause_rd_en) begin
            clause_mask <= mask_m[clause_addr[2:0]];
            clause_pole <= pole_m[clause_addr[2:0]];
            unassign    <= un_m[clause_addr[2:0]];
            val         <= val_m[clause_addr[2:0]];
            variable    <= var_m[clause_addr[2:0]];
        end
    end

    int stall_n;
    int wait_cnt;
    initial imp_ready = 1'b0;
    always @(posedge clock) begin
        #2;
        if (imp_valid) begin
            imp_ready = (wait_cnt >= stall_n);
            wait_cnt++;
        end else begin
            imp_ready = (stall_n == 0);
            wait_cnt  = 0;
        end
    end

    int   rd_log [$];
    int   done_cnt;
    int   imp_cycles;
    int   xfers;
    int   unstable;
    int   overlap;
    logic prev_valid;
    logic prev_ready;
    logic [7:0] prev_var;
    logic prev_val;
    logic [7:0] last_var;
    logic last_val;

    always @(negedge clock) begin
        if (reset_n) begin
            if (clause_rd_en) rd_log.push_back(int'(clause_addr));
            if (done) done_cnt++;
            if (imp_valid) begin
                imp_cycles++;
                last_var = imp_var;
                last_val = imp_val;
                if (clause_rd_en) overlap++;
                if (prev_valid && !prev_ready &&
                    (imp_var != prev_var || imp_val != prev_val))
                    unstable++;
                if (imp_ready) xfers++;
            end
            prev_valid = imp_valid;
            prev_ready = imp_ready;
            prev_var   = imp_var;
            prev_val   = imp_val;
        end
    end

    int total;
    int bad;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_neutral(input int i);
        mask_m[i] = 5'b00001;
        pole_m[i] = 5'b00000;
        un_m[i]   = 5'b00000;
        val_m[i]  = 5'b00001;
        var_m[i]  = '0;
    endtask

    task automatic set_unit(input int i, input logic [4:0] pole);
        mask_m[i]    = 5'b11111;
        pole_m[i]    = pole;
        un_m[i]      = 5'b10000;
        val_m[i]     = 5'b00000;
        var_m[i]     = '0;
        var_m[i][4]  = 8'd9;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        done_cnt   = 0;
        imp_cycles = 0;
        xfers      = 0;
        unstable   = 0;
        overlap    = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        last_var   = '0;
        last_val   = 1'b0;
    endtask

    task automatic run_pass(input logic [7:0] n, input int budget,
                            output int cyc);
        clear_logs();
        @(negedge clock);
        start       = 1'b1;
        num_clauses = n;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        #1;
        chk("done_seen", done, 1);
    endtask

    int cyc;

    initial begin
        total       = 0;
        bad         = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_clauses = '0;
        stall_n     = 0;
        for (int i = 0; i < 8; i++) set_neutral(i);
        clear_logs();
        repeat (2) @(negedge clock);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_cclause", conflict_clause, 0);
        chk("rst_rd_en", clause_rd_en, 0);
        chk("rst_imp_valid", imp_valid, 0);
        chk("rst_imp_var", imp_var, 0);
        chk("rst_imp_val", imp_val, 0);
        reset_n = 1'b1;

        // plain pass over three satisfied clauses
        run_pass(8'd3, 40, cyc);
        chk("s1_done_cyc", cyc, 7);
        chk("s1_conflict", conflict, 0);
        chk("s1_rd_count", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            chk("s1_addr0", rd_log[0], 0);
            chk("s1_addr1", rd_log[1], 1);
            chk("s1_addr2", rd_log[2], 2);
        end
        chk("s1_done_cnt", done_cnt, 1);
        @(negedge clock);
        chk("s1_idle_busy", busy, 0);

        // unit clause, consumer always ready
        set_unit(1, 5'b00000);
        stall_n = 0;
        run_pass(8'd3, 40, cyc);
        chk("s2_done_cyc", cyc, 8);
        chk("s2_imp_cycles", imp_cycles, 1);
        chk("s2_xfers", xfers, 1);
        chk("s2_imp_var", last_var, 9);
        chk("s2_imp_val", last_val, 1);
        chk("s2_rd_count", rd_log.size(), 3);
        chk("s2_conflict", conflict, 0);

        // unit clause with a four cycle stall
        set_unit(1, 5'b10000);
        stall_n = 4;
        run_pass(8'd3, 40, cyc);
        chk("s3_done_cyc", cyc, 12);
        chk("s3_imp_cycles", imp_cycles, 5);
        chk("s3_xfers", xfers, 1);
        chk("s3_imp_var", last_var, 9);
        chk("s3_imp_val", last_val, 0);
        chk("s3_unstable", unstable, 0);
        chk("s3_rd_overlap", overlap, 0);
        chk("s3_rd_count", rd_log.size(), 3);

        // conflict on clause 2 of 4
        stall_n = 0;
        set_neutral(1);
        mask_m[2] = 5'b00111;
        pole_m[2] = 5'b00000;
        un_m[2]   = 5'b00000;
        val_m[2]  = 5'b00000;
        run_pass(8'd4, 40, cyc);
        chk("s4_done_cyc", cyc, 7);
        chk("s4_conflict", conflict, 1);
        chk("s4_cclause", conflict_clause, 2);
        chk("s4_rd_count", rd_log.size(), 3);
        repeat (2) @(negedge clock);
        chk("s4_conflict_hold", conflict, 1);
        chk("s4_idle_busy", busy, 0);

        // empty pass, also clears the held conflict
        run_pass(8'd0, 10, cyc);
        chk("s5_done_cyc", cyc, 1);
        chk("s5_rd_count", rd_log.size(), 0);
        chk("s5_conflict", conflict, 0);

        // clause with no lanes in use is skipped
        mask_m[0] = 5'b00000;
        un_m[0]   = 5'b11111;
        val_m[0]  = 5'b00000;
        pole_m[0] = 5'b00000;
        set_neutral(1);
        run_pass(8'd2, 20, cyc);
        chk("s5b_done_cyc", cyc, 5);
        chk("s5b_imp_cycles", imp_cycles, 0);
        chk("s5b_conflict", conflict, 0);
        chk("s5b_rd_count", rd_log.size(), 2);

        // abort while an implication is stalled
        set_unit(0, 5'b00000);
        stall_n = 100;
        clear_logs();
        @(negedge clock);
        start       = 1'b1;
        num_clauses = 8'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("s6_emit_valid", imp_valid, 1);
        chk("s6_emit_var", imp_var, 9);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("s6_abort_busy", busy, 0);
        chk("s6_abort_valid", imp_valid, 0);
        chk("s6_abort_conflict", conflict, 0);
        repeat (2) @(negedge clock);
        chk("s6_abort_nodone", done_cnt, 0);

        // reset asserted while fetching
        set_neutral(0);
        @(negedge clock);
        start       = 1'b1;
        num_clauses = 8'd3;
        @(negedge clock);
        start = 1'b0;
        chk("s6_fetch_rd_en", clause_rd_en, 1);
        reset_n = 1'b0;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_rd_en", clause_rd_en, 0);
        chk("s6_rst_valid", imp_valid, 0);
        chk("s6_rst_imp_var", imp_var, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("s6_rst_nodone", done_cnt, 0);

        stall_n = 0;
        run_pass(8'd1, 20, cyc);
        chk("s6_after_done_cyc", cyc, 3);
        chk("s6_after_conflict", conflict, 0);
        chk("s6_after_rd_count", rd_log.size(), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
